// File: rtl/pc_unit_pkg.sv
// Shared constants and the operation decode used by the program counter.
// The boot address lives here so other datapath blocks agree on it.
package pc_unit_pkg;

    localparam int          PC_DATA_WIDTH  = 16;
    localparam int unsigned PC_RESET_VALUE = 32'h0000_0000;

    typedef enum logic [1:0] {
        OP_HOLD = 2'd0,
        OP_INC  = 2'd1,
        OP_LOAD = 2'd2
    } pc_op_e;

    // A load always beats an increment on the same edge.
    function automatic pc_op_e decode_op(input logic load_n, input logic inc);
        if (!load_n) begin
            return OP_LOAD;
        end else if (inc) begin
            return OP_INC;
        end
        return OP_HOLD;
    endfunction

endpackage

// File: rtl/pc_tristate_driver.sv
// Parameterised bus driver: passes its input when enabled, floats otherwise.
// Shared by any register that sits on the common data bus.
module pc_tristate_driver #(
    parameter int WIDTH = 16
) (
    input  logic             enable,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out
);

    assign data_out = enable ? data_in : {WIDTH{1'bz}};

endmodule

// File: rtl/pc_unit.sv
// Program counter on the shared data bus: clear, parallel load and increment,
// with a tri-stated read port that shows the registered value.
module pc_unit
    import pc_unit_pkg::*;
#(
    parameter int                    DATA_WIDTH  = PC_DATA_WIDTH,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = DATA_WIDTH'(PC_RESET_VALUE)
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  notWrite,
    input  logic                  read,
    input  logic                  inc,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out
);

    logic [DATA_WIDTH-1:0] pc;
    pc_op_e                op;

    always_comb begin
        op = decode_op(notWrite, inc);
    end

    // Clear outranks everything; the increment wraps naturally at the word width.
    always_ff @(posedge clk) begin
        if (clr) begin
            pc <= RESET_VALUE;
        end else begin
            unique case (op)
                OP_LOAD: pc <= data_in;
                OP_INC:  pc <= pc + DATA_WIDTH'(1);
                default: pc <= pc;
            endcase
        end
    end

    pc_tristate_driver #(
        .WIDTH(DATA_WIDTH)
    ) u_out_driver (
        .enable  (read),
        .data_in (pc),
        .data_out(data_out)
    );

endmodule

// File: tb/tb_pc_unit.sv
// Directed and randomized checks of pc_unit against a simple arithmetic model,
// including bus release when read is low.
module tb_pc_unit;

    logic        clk;
    logic        clr;
    logic        notWrite;
    logic        read;
    logic        inc;
    logic [15:0] data_in;
    tri   [15:0] out_bus;

    logic        drive_en;
    logic [15:0] drive_val;

    int          compared;
    int          mismatched;
    int unsigned model_pc;
    logic [15:0] seen;

    assign out_bus = drive_en ? drive_val : 16'bz;

    pc_unit dut (
        .clk     (clk),
        .clr     (clr),
        .notWrite(notWrite),
        .read    (read),
        .inc     (inc),
        .data_in (data_in),
        .data_out(out_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one edge's worth of controls, then advance the model by the same rules.
    task automatic applyStimulus(input logic c, input logic nw, input logic i, input logic [15:0] d);
        @(negedge clk);
        clr      = c;
        notWrite = nw;
        inc      = i;
        data_in  = d;
        @(posedge clk);
        if (c)        model_pc = 0;
        else if (!nw) model_pc = d;
        else if (i)   model_pc = (model_pc + 1) % 65536;
        #1;
        clr      = 1'b0;
        notWrite = 1'b1;
        inc      = 1'b0;
    endtask

    task automatic readValue(output logic [15:0] v);
        drive_en = 1'b0;
        read     = 1'b1;
        #1;
        v    = out_bus;
        read = 1'b0;
        #1;
    endtask

    // Read the PC, then prove the bus is released by driving two complementary patterns.
    task automatic checkOutput(input string tag);
        logic [15:0] p;
        readValue(seen);
        check({tag, "_read"}, seen, model_pc[15:0]);
        p         = 16'($urandom);
        drive_val = p;
        drive_en  = 1'b1;
        #1;
        check({tag, "_float_a"}, out_bus, p);
        drive_val = ~p;
        #1;
        check({tag, "_float_b"}, out_bus, ~p);
        drive_en = 1'b0;
    endtask

    initial begin
        logic c, nw, i;
        logic [15:0] d;
        compared   = 0;
        mismatched = 0;
        model_pc   = 0;
        clr        = 1'b0;
        notWrite   = 1'b1;
        read       = 1'b0;
        inc        = 1'b0;
        data_in    = 16'h0000;
        drive_en   = 1'b0;
        drive_val  = 16'h0000;

        $display("[TB] starting pc_unit checks");

        applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000);
        readValue(seen);
        check("clear", seen, 16'h0000);
        checkOutput("clear");

        applyStimulus(1'b0, 1'b0, 1'b0, 16'hDEAD);
        checkOutput("load_dead");
        applyStimulus(1'b0, 1'b1, 1'b1, 16'h0000);
        readValue(seen);
        check("inc_deae", seen, 16'hDEAE);
        checkOutput("inc");

        applyStimulus(1'b0, 1'b0, 1'b0, 16'hFFFF);
        applyStimulus(1'b0, 1'b1, 1'b1, 16'h0000);
        readValue(seen);
        check("wrap", seen, 16'h0000);
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0042);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 16'h5555);
        end
        readValue(seen);
        check("hold", seen, 16'h0042);

        applyStimulus(1'b0, 1'b0, 1'b1, 16'h1234);
        readValue(seen);
        check("load_over_inc", seen, 16'h1234);
        applyStimulus(1'b1, 1'b0, 1'b1, 16'h4321);
        readValue(seen);
        check("clr_over_all", seen, 16'h0000);

        // read held across a load edge: old value before, new value after
        applyStimulus(1'b0, 1'b0, 1'b0, 16'hBEEF);
        @(negedge clk);
        read     = 1'b1;
        notWrite = 1'b0;
        data_in  = 16'hCAFE;
        #1;
        check("read_during_load_pre", out_bus, 16'hBEEF);
        @(posedge clk);
        #1;
        check("read_during_load_post", out_bus, 16'hCAFE);
        model_pc = 16'hCAFE;
        notWrite = 1'b1;

        @(negedge clk);
        clr = 1'b1;
        #1;
        check("read_during_clr_pre", out_bus, 16'hCAFE);
        @(posedge clk);
        #1;
        check("read_during_clr_post", out_bus, 16'h0000);
        model_pc = 0;
        clr      = 1'b0;
        read     = 1'b0;

        for (int n = 0; n < 300; n++) begin
            c  = ($urandom_range(0, 15) == 0);
            nw = ($urandom_range(0, 2) != 0);
            i  = $urandom_range(0, 1) == 1;
            d  = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
            applyStimulus(c, nw, i, d);
            checkOutput("random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout observed=running expected=finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Program counter register for the CPU datapath, sitting on the shared data bus.
- Supports synchronous clear, parallel load from the bus, and increment by one.
- Drives its current value onto the bus only when read is asserted; otherwise its output is high-impedance.
- data_in and data_out may be tied to the same bus net.

Parameters:
- DATA_WIDTH, 16, width of the PC register and both data ports.
- RESET_VALUE, 0, value loaded on clear.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- clr  input  1  synchronous, active-high reset/clear.
- notWrite  input  1  active-low load enable; when 0, the PC loads data_in at the rising edge.
- read  input  1  active-high output enable for data_out.
- inc  input  1  active-high increment enable.
- data_in  input  DATA_WIDTH  load value from the bus.
- data_out  output  DATA_WIDTH  PC value when read=1; all bits Z when read=0.

Behaviour:
- Single internal register pc[DATA_WIDTH-1:0]. Its power-up value is undefined until the first clr.
- Priority at each rising clk edge, highest first:
  1. clr=1 -> pc <= RESET_VALUE.
  2. notWrite=0 -> pc <= data_in.
  3. inc=1 -> pc <= pc + 1.
  4. Otherwise pc holds.
- Simultaneous load and inc: the load wins and no increment is applied. Simultaneous clr with anything: clr wins.
- Increment is modulo 2^DATA_WIDTH, so all-ones + 1 wraps to 0. There is no carry output.
- Load latency: the new value is visible on the cycle after the edge. Increment latency: one cycle.
- data_out is combinational: read=1 -> data_out = pc (the registered value, not the next value); read=0 -> all Z.
- read does not affect pc state.
- read asserted during a load: data_out shows the old pc until the edge, then the new value. The system controller must not assert read while another driver owns the bus; the block itself performs no bus arbitration.
- Reset mid-operation: clr overrides any pending load or increment on that edge. data_out follows read even while clr is asserted, so read=1 during clr shows the pre-edge value, then RESET_VALUE.
- X/Z on data_in is loaded as-is when notWrite=0.
- No handshake; every operation completes in a single cycle.

Decomposition:
- Shared package: DATA_WIDTH default (word width constant) and the RESET_VALUE constant for the CPU's boot address.
- One natural sub-module: pc_tristate_driver, a parameterised-width bus driver (enable -> pass, else Z), reusable by other bus-attached registers.
- The register and next-state logic stay in pc_unit.

Test Plan:
- Clear: clr=1 for one edge -> pc=0x0000; then read=1 -> data_out=0x0000.
- Load: bus=0xDEAD, notWrite=0 for one edge -> pc=0xDEAD; with read=0, data_out stays Z throughout.
- Increment: after the load, inc=1 for one edge -> pc=0xDEAE; read=1 -> data_out=0xDEAE; read=0 -> Z.
- Wrap and hold: load 0xFFFF, inc for one edge -> 0x0000; inc=0 and notWrite=1 for 3 edges -> value unchanged.
- Priority:
  - notWrite=0 with data 0x1234 and inc=1 together -> pc=0x1234 (no increment).
  - clr=1 with notWrite=0 and inc=1 -> pc=0x0000.
- Output enable timing: read toggled between edges -> data_out changes combinationally with read, independent of clk.
